// File: rtl/gf_poly_mul_seq_if.sv
// Handshake and multiplier-port bundle for gf_poly_mul_seq.
// master = environment (producer, consumer, external gf_mul); slave = controller.
interface gf_poly_mul_seq_if #(
    parameter int unsigned SIZE = 8,
    parameter int unsigned N    = 2
);
    localparam int unsigned FLAT_W = (N + 1) * SIZE;
    localparam int unsigned Z_W    = (2 * N + 1) * SIZE;

    logic              in_valid;
    logic              in_ready;
    logic [FLAT_W-1:0] flat_p;
    logic [FLAT_W-1:0] flat_q;
    logic              mul_en;
    logic [SIZE-1:0]   mul_a;
    logic [SIZE-1:0]   mul_b;
    logic [SIZE-1:0]   mul_prod;
    logic              out_valid;
    logic              out_ready;
    logic [Z_W-1:0]    flat_z;
    logic              busy;

    modport master (
        output in_valid, flat_p, flat_q, mul_prod, out_ready,
        input  in_ready, mul_en, mul_a, mul_b, out_valid, flat_z, busy
    );

    modport slave (
        input  in_valid, flat_p, flat_q, mul_prod, out_ready,
        output in_ready, mul_en, mul_a, mul_b, out_valid, flat_z, busy
    );
endinterface

// File: rtl/gf_poly_mul_seq.sv
// Sequential GF(2^8) polynomial multiplier: one coefficient product per cycle through an
// external gf_mul, XOR-accumulated. Optional macro GF_SEQ_SKIP_ZERO_EN skips rows where p[i]==0.
module gf_poly_mul_seq #(
    parameter int unsigned m    = 255,
    parameter int unsigned SIZE = $clog2(m),
    parameter int unsigned n    = 2
) (
    input logic              clk,
    input logic              rst_n,
    gf_poly_mul_seq_if.slave bus
);
    localparam int unsigned flat_size        = (n + 1) * SIZE;
    localparam int unsigned large_array      = 2 * n;
    localparam int unsigned large_array_size = (large_array + 1) * SIZE;
    localparam int unsigned CW               = (n > 0) ? $clog2(n + 1) : 1;
    localparam int unsigned KW               = (n > 0) ? $clog2(large_array + 1) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    state_e                         state_q, state_d;
    logic [n:0][SIZE-1:0]           p_q, p_d;
    logic [n:0][SIZE-1:0]           q_q, q_d;
    logic [large_array:0][SIZE-1:0] acc_q, acc_d;
    logic [CW-1:0]                  i_q, i_d;
    logic [CW-1:0]                  j_q, j_d;
    logic [KW-1:0]                  k_c;
    logic                           skip_c;
    logic                           in_ready_q, in_ready_d;
    logic                           busy_q, busy_d;
    logic                           out_valid_q, out_valid_d;
    logic                           mul_en_q, mul_en_d;
    logic [SIZE-1:0]                mul_a_q, mul_a_d;
    logic [SIZE-1:0]                mul_b_q, mul_b_d;

    // Next-state, accumulator update and next registered outputs
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_c     = KW'(i_q) + KW'(j_q);
        skip_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    p_d     = bus.flat_p[flat_size-1:0];
                    q_d     = bus.flat_q[flat_size-1:0];
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
`ifdef GF_SEQ_SKIP_ZERO_EN
                skip_c = (j_q == '0) && (p_q[i_q] == '0);
`endif
                if (!skip_c) begin
                    acc_d[k_c] = acc_q[k_c] ^ bus.mul_prod;
                end
                if (!skip_c && (j_q != CW'(n))) begin
                    j_d = j_q + 1'b1;
                end else begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end
                if ((i_q == CW'(n)) && (skip_c || (j_q == CW'(n)))) begin
                    i_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from next state so they are live in the cycle they describe
        mul_en_d = (state_d == MUL);
`ifdef GF_SEQ_SKIP_ZERO_EN
        if ((j_d == '0) && (p_d[i_d] == '0)) begin
            mul_en_d = 1'b0;
        end
`endif
        mul_a_d     = mul_en_d ? p_d[i_d] : '0;
        mul_b_d     = mul_en_d ? q_d[j_d] : '0;
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            q_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            mul_en_q    <= mul_en_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mul_en    = mul_en_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.flat_z    = large_array_size'(acc_q);

endmodule
